// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS-style controller: state codes,
// opcode/funct values and ALU control encodings.
package mc_pkg;

   typedef logic [3:0] state_t;

   localparam state_t StFetch   = 4'd0;
   localparam state_t StDecode  = 4'd1;
   localparam state_t StMemAdr  = 4'd2;
   localparam state_t StMemRd   = 4'd3;
   localparam state_t StMemWb   = 4'd4;
   localparam state_t StMemWr   = 4'd5;
   localparam state_t StRtypeEx = 4'd6;
   localparam state_t StRtypeWb = 4'd7;
   localparam state_t StBeqEx   = 4'd8;
   localparam state_t StAddiEx  = 4'd9;
   localparam state_t StAddiWb  = 4'd10;
   localparam state_t StJEx     = 4'd11;
   localparam state_t StIllegal = 4'd12;

   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpJ     = 6'b000010;

   localparam logic [5:0] FnAdd = 6'b100000;
   localparam logic [5:0] FnSub = 6'b100010;
   localparam logic [5:0] FnAnd = 6'b100100;
   localparam logic [5:0] FnOr  = 6'b100101;
   localparam logic [5:0] FnSlt = 6'b101010;

   localparam logic [2:0] AluSlt = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAdd = 3'b101;
   localparam logic [2:0] AluOr  = 3'b110;
   localparam logic [2:0] AluAnd = 3'b111;

   localparam logic [1:0] PcSrcAlu    = 2'b00;
   localparam logic [1:0] PcSrcAluOut = 2'b01;
   localparam logic [1:0] PcSrcJump   = 2'b10;

   localparam logic [1:0] SrcBReg    = 2'b00;
   localparam logic [1:0] SrcBFour   = 2'b01;
   localparam logic [1:0] SrcBImm    = 2'b10;
   localparam logic [1:0] SrcBImmSh2 = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU control decoder; funct_valid flags supported codes.
module alu_decoder
   import mc_pkg::*;
(
   input  logic [5:0] funct_i,
   output logic [2:0] alucontrol_o,
   output logic       funct_valid_o
);

   always_comb begin
      alucontrol_o  = AluSlt;
      funct_valid_o = 1'b1;
      case (funct_i)
         FnAdd:   alucontrol_o = AluAdd;
         FnSub:   alucontrol_o = AluSub;
         FnAnd:   alucontrol_o = AluAnd;
         FnOr:    alucontrol_o = AluOr;
         FnSlt:   alucontrol_o = AluSlt;
         default: funct_valid_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM controller for a multicycle MIPS subset (lw, sw, R-type, beq, addi, j).
// Define MEM_WAIT_EN to add mem_ready handshaking on FETCH, MEMRD and MEMWR.
module multicycle_controller
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
`ifdef MEM_WAIT_EN
   input  logic       mem_ready,
`endif
   output logic       pcen,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic       illegal,
   output logic [1:0] pcsrc,
   output logic [1:0] alusrcb,
   output logic [2:0] alucontrol
);

   state_t     state_q, state_d;
   logic [2:0] rtype_alu;
   logic       funct_valid;
   logic       mem_ok;
   logic       pcen_s, memwrite_s, irwrite_s, regwrite_s;

`ifdef MEM_WAIT_EN
   assign mem_ok = mem_ready;
`else
   assign mem_ok = 1'b1;
`endif

   alu_decoder u_alu_decoder (
      .funct_i       (funct),
      .alucontrol_o  (rtype_alu),
      .funct_valid_o (funct_valid)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StFetch:   if (mem_ok) state_d = StDecode;
         StDecode: begin
            case (opcode)
               OpLw, OpSw: state_d = StMemAdr;
               OpRtype:    state_d = StRtypeEx;
               OpBeq:      state_d = StBeqEx;
               OpAddi:     state_d = StAddiEx;
               OpJ:        state_d = StJEx;
               default:    state_d = StIllegal;
            endcase
         end
         StMemAdr:  state_d = (opcode == OpSw) ? StMemWr : StMemRd;
         StMemRd:   if (mem_ok) state_d = StMemWb;
         StMemWr:   if (mem_ok) state_d = StFetch;
         StRtypeEx: state_d = funct_valid ? StRtypeWb : StIllegal;
         StAddiEx:  state_d = StAddiWb;
         StMemWb, StRtypeWb, StAddiWb, StBeqEx, StJEx: state_d = StFetch;
         StIllegal: state_d = StIllegal;
         default:   state_d = StFetch;
      endcase
   end

   always_comb begin
      pcen_s     = 1'b0;
      iord       = 1'b0;
      memwrite_s = 1'b0;
      irwrite_s  = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite_s = 1'b0;
      alusrca    = 1'b0;
      illegal    = 1'b0;
      pcsrc      = PcSrcAlu;
      alusrcb    = SrcBReg;
      alucontrol = AluSlt;
      case (state_q)
         StFetch: begin
            irwrite_s  = mem_ok;
            pcen_s     = mem_ok;
            alusrcb    = SrcBFour;
            alucontrol = AluAdd;
         end
         StDecode: begin
            alusrcb    = SrcBImmSh2;
            alucontrol = AluAdd;
         end
         StMemAdr, StAddiEx: begin
            alusrca    = 1'b1;
            alusrcb    = SrcBImm;
            alucontrol = AluAdd;
         end
         StMemRd:   iord = 1'b1;
         StMemWb: begin
            memtoreg   = 1'b1;
            regwrite_s = 1'b1;
         end
         StMemWr: begin
            iord       = 1'b1;
            memwrite_s = mem_ok;
         end
         StRtypeEx: begin
            alusrca    = 1'b1;
            alucontrol = rtype_alu;
         end
         StRtypeWb: begin
            regdst     = 1'b1;
            regwrite_s = 1'b1;
         end
         StAddiWb:  regwrite_s = 1'b1;
         StBeqEx: begin
            alusrca    = 1'b1;
            alucontrol = AluSub;
            pcsrc      = PcSrcAluOut;
            pcen_s     = zero;
         end
         StJEx: begin
            pcsrc  = PcSrcJump;
            pcen_s = 1'b1;
         end
         StIllegal: illegal = 1'b1;
         default: ;
      endcase
   end

   // Write enables are masked by reset so nothing is written while it is held.
   assign pcen     = pcen_s & reset;
   assign irwrite  = irwrite_s & reset;
   assign memwrite = memwrite_s & reset;
   assign regwrite = regwrite_s & reset;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock.
REQ-002 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port opcode, input, 6, instr[31:26] from instruction register.
REQ-004 SHALL have port funct, input, 6, instr[5:0].
REQ-005 SHALL have port zero, input, 1, ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1, memory access complete (present only with MEM_WAIT_EN).
REQ-007 SHALL have outputs, each 1 bit: pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal.
REQ-008 SHALL have outputs pcsrc (2; 00 ALU, 01 ALUOut, 10 jump), alusrcb (2; 00 reg, 01 const 4, 10 signimm, 11 signimm<<2), alucontrol (3).

Function
REQ-009 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, ILLEGAL.
REQ-010 SHALL use alucontrol encoding: 000 slt, 001 sub, 101 add, 110 or, 111 and.
REQ-011 FETCH SHALL drive iord=0, irwrite=1, alusrca=0, alusrcb=01, alucontrol=101, pcsrc=00, pcen=1; next DECODE.
REQ-012 DECODE SHALL drive alusrca=0, alusrcb=11, alucontrol=101; next by opcode: 100011/101011 MEMADR, 000000 RTYPEEX, 000100 BEQEX, 001000 ADDIEX, 000010 JEX, other ILLEGAL.
REQ-013 MEMADR SHALL drive alusrca=1, alusrcb=10, alucontrol=101; next MEMRD for lw, MEMWR for sw.
REQ-014 MEMRD: iord=1, next MEMWB; MEMWB: regdst=0, memtoreg=1, regwrite=1, next FETCH.
REQ-015 MEMWR: iord=1, memwrite=1, next FETCH.
REQ-016 RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); unknown funct SHALL go to ILLEGAL instead of RTYPEWB.
REQ-017 RTYPEWB: regdst=1, memtoreg=0, regwrite=1; ADDIEX: alusrca=1, alusrcb=10, alucontrol=101; ADDIWB: regdst=0, regwrite=1; both next FETCH.
REQ-018 BEQEX: alusrca=1, alusrcb=00, alucontrol=001, pcsrc=01, pcen=zero; JEX: pcsrc=10, pcen=1; both next FETCH.
REQ-019 ILLEGAL SHALL be absorbing until reset, illegal=1, all write enables (pcen, irwrite, memwrite, regwrite) 0.
REQ-020 Unlisted outputs in any state SHALL be 0.
REQ-021 Cycles per instruction (no wait): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-022 While reset=0 the FSM SHALL be forced to FETCH asynchronously and pcen, irwrite, memwrite, regwrite SHALL be 0 regardless of state.
REQ-023 On the first rising clk after reset deasserts, FETCH SHALL perform its full fetch (irwrite=1, pcen=1).
REQ-024 Reset asserted mid-instruction SHALL abort it; no partial writes after assertion.

Configuration
REQ-025 With MEM_WAIT_EN defined, FETCH, MEMRD and MEMWR SHALL hold while mem_ready=0 with irwrite, pcen, memwrite gated to 0 except in the cycle mem_ready=1; state advances only on mem_ready=1.
REQ-026 Without MEM_WAIT_EN, mem_ready port SHALL not exist and every state SHALL last exactly one cycle.

Structure
REQ-027 Package mc_pkg SHALL hold the state enum, opcode and funct constants, and alucontrol encodings.
REQ-028 Funct-to-alucontrol mapping SHALL be a sub-module alu_decoder (combinational, outputs alucontrol and funct_valid).

Verification
REQ-029 Reset low 3 cycles, release -> first cycle FETCH with irwrite=1, pcen=1, alusrcb=01, alucontrol=101.
REQ-030 opcode=100011 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1, memtoreg=1 only in cycle 5.
REQ-031 opcode=000100 with zero=1 -> pcen=1, pcsrc=01 in cycle 3; with zero=0 -> pcen=0, next FETCH.
REQ-032 opcode=000000, funct=101010 -> alucontrol=000 in RTYPEEX, regdst=1, regwrite=1 in RTYPEWB; funct=111111 -> illegal=1, held until reset.
REQ-033 MEM_WAIT_EN, sw, mem_ready=0 for 3 cycles in MEMWR -> memwrite=0 during wait, memwrite=1 for exactly one cycle when mem_ready=1, then FETCH.
REQ-034 Reset asserted during MEMWB of lw -> regwrite drops to 0 immediately, FSM in FETCH.
